// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing, stalls on mem_ready.
// Optional illegal-instruction trap state enabled by `define MIPS_CTRL_TRAP_EN.
module mips_multicycle_ctrl #(
  parameter logic [1:0] FETCH_INC = 2'b01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic [3:0] aluop,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_en,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       exc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    ADDI_EXEC = 4'd8,
    ADDI_WB   = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11,
    TRAP      = 4'd12
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;

`ifdef MIPS_CTRL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = TRAP;
`else
  localparam state_t ILLEGAL_NEXT = FETCH;
`endif

  state_t st, nxt;

  // {legal, aluop} for an R-type funct field
  function automatic logic [4:0] r_decode(input logic [5:0] f);
    case (f)
      6'h20:   r_decode = {1'b1, 4'b0000};
      6'h22:   r_decode = {1'b1, 4'b0010};
      6'h24:   r_decode = {1'b1, 4'b0100};
      6'h25:   r_decode = {1'b1, 4'b0101};
      6'h27:   r_decode = {1'b1, 4'b0111};
      6'h2A:   r_decode = {1'b1, 4'b1010};
      default: r_decode = {1'b0, 4'b0000};
    endcase
  endfunction

  logic [4:0] r_dec;
  assign r_dec = r_decode(funct);

  always_comb begin
    nxt = st;
    case (st)
      FETCH:     if (mem_ready) nxt = DECODE;
      DECODE: begin
        case (opcode)
          6'h00:        nxt = r_dec[4] ? R_EXEC : ILLEGAL_NEXT;
          6'h23, 6'h2B: nxt = MEM_ADDR;
          6'h04, 6'h05: nxt = BRANCH;
          6'h08:        nxt = ADDI_EXEC;
          6'h02:        nxt = JUMP;
          default:      nxt = ILLEGAL_NEXT;
        endcase
      end
      MEM_ADDR:  nxt = (opcode == 6'h2B) ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (mem_ready) nxt = MEM_WB;
      MEM_WRITE: if (mem_ready) nxt = FETCH;
      R_EXEC:    nxt = R_WB;
      ADDI_EXEC: nxt = ADDI_WB;
      default:   nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) st <= FETCH;
    else     st <= nxt;
  end

  assign state = st;

  // Moore decode from st; only the handshake, branch and funct terms look at inputs.
  always_comb begin
    aluop      = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    exc        = 1'b0;
    if (!rst) begin
      case (st)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = FETCH_INC;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
        end
        DECODE:    alu_src_b = 2'b11;
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_READ: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        MEM_WRITE: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        R_EXEC: begin
          alu_src_a = 1'b1;
          aluop     = r_dec[3:0];
        end
        R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          aluop      = ALU_SUB;
          pc_source  = 2'b01;
          pc_en      = (opcode == 6'h05) ? ~zero_flag : zero_flag;
          instr_done = 1'b1;
        end
        JUMP: begin
          pc_source  = 2'b10;
          pc_en      = 1'b1;
          instr_done = 1'b1;
        end
`ifdef MIPS_CTRL_TRAP_EN
        TRAP: begin
          exc       = 1'b1;
          pc_source = 2'b11;
          pc_en     = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven per-cycle check of mips_multicycle_ctrl plus hand-written lw/sw stall sequences.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero_flag, mem_ready;
  logic [3:0] aluop;
  logic       alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic       pc_en, ir_write, iord, mem_read, mem_write, reg_write;
  logic       reg_dst, mem_to_reg, instr_done, exc;
  logic [3:0] state;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .aluop(aluop),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .pc_en(pc_en), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .instr_done(instr_done), .exc(exc), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] SF = 4'd0, SD = 4'd1, SMA = 4'd2, SMR = 4'd3, SMWB = 4'd4,
                         SMW = 4'd5, SRE = 4'd6, SRW = 4'd7, SAE = 4'd8, SAW = 4'd9,
                         SBR = 4'd10, SJ = 4'd11, ST = 4'd12;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] aluop;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] ps;
    logic [9:0] bits; // pc_en ir_write iord mem_read mem_write reg_write reg_dst mem_to_reg instr_done exc
  } out_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       mr;
    out_t       exp;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  function automatic out_t sample();
    out_t a;
    a.st    = state;
    a.aluop = aluop;
    a.sa    = alu_src_a;
    a.sb    = alu_src_b;
    a.ps    = pc_source;
    a.bits  = {pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
               mem_to_reg, instr_done, exc};
    return a;
  endfunction

  task automatic row(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic mr, input logic [3:0] st,
                     input logic [3:0] al, input logic sa, input logic [1:0] sb,
                     input logic [1:0] ps, input logic [9:0] bits);
    vec_t v;
    v.rst = r; v.op = op; v.fn = fn; v.z = z; v.mr = mr;
    v.exp.st = st; v.exp.aluop = al; v.exp.sa = sa; v.exp.sb = sb;
    v.exp.ps = ps; v.exp.bits = bits;
    tbl.push_back(v);
  endtask

  // One R-type instruction with mem_ready=1
  task automatic r_instr(input logic [5:0] fn, input logic [3:0] al);
    row(0, 6'h00, fn, 0, 1, SF,  4'b0000, 0, 2'b01, 2'b00, 10'b1101000000);
    row(0, 6'h00, fn, 0, 1, SD,  4'b0000, 0, 2'b11, 2'b00, 10'b0000000000);
    row(0, 6'h00, fn, 0, 1, SRE, al,      1, 2'b00, 2'b00, 10'b0000000000);
    row(0, 6'h00, fn, 0, 1, SRW, 4'b0000, 0, 2'b00, 2'b00, 10'b0000011010);
  endtask

  task automatic br_instr(input logic [5:0] op, input logic z, input logic pe);
    row(0, op, 6'h00, z, 1, SF,  4'b0000, 0, 2'b01, 2'b00, 10'b1101000000);
    row(0, op, 6'h00, z, 1, SD,  4'b0000, 0, 2'b11, 2'b00, 10'b0000000000);
    row(0, op, 6'h00, z, 1, SBR, 4'b0010, 1, 2'b00, 2'b01, {pe, 9'b000000010});
  endtask

  task automatic illegal_instr(input logic [5:0] op, input logic [5:0] fn);
    row(0, op, fn, 0, 1, SF, 4'b0000, 0, 2'b01, 2'b00, 10'b1101000000);
    row(0, op, fn, 0, 1, SD, 4'b0000, 0, 2'b11, 2'b00, 10'b0000000000);
`ifdef MIPS_CTRL_TRAP_EN
    row(0, op, fn, 0, 1, ST, 4'b0000, 0, 2'b00, 2'b11, 10'b1000000001);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input out_t act, input out_t exp, input logic mask_st);
    out_t a;
    out_t e;
    a = act; e = exp;
    if (mask_st) begin a.st = 4'd0; e.st = 4'd0; end
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got st=%0d alu=%b sa=%b sb=%b ps=%b bits=%b, want st=%0d alu=%b sa=%b sb=%b ps=%b bits=%b",
               name, a.st, a.aluop, a.sa, a.sb, a.ps, a.bits, e.st, e.aluop, e.sa, e.sb, e.ps, e.bits);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    int k, cyc, done_cnt, rw_cnt, viol;
    bit seen;
    rst = 1; opcode = 0; funct = 0; zero_flag = 0; mem_ready = 0;
    repeat (2) step();

    // reset state: outputs all 0 while rst high
    row(1, 6'h23, 6'h00, 0, 1, SF, 4'b0000, 0, 2'b00, 2'b00, 10'b0000000000);
    // add / sub / slt / nor
    r_instr(6'h20, 4'b0000);
    // FETCH stall before the sub
    row(0, 6'h00, 6'h22, 0, 0, SF, 4'b0000, 0, 2'b01, 2'b00, 10'b0001000000);
    r_instr(6'h22, 4'b0010);
    r_instr(6'h2A, 4'b1010);
    r_instr(6'h27, 4'b0111);
    r_instr(6'h24, 4'b0100);
    // lw, three stall cycles in MEM_READ: 8 rows
    row(0, 6'h23, 6'h00, 0, 1, SF,   4'b0000, 0, 2'b01, 2'b00, 10'b1101000000);
    row(0, 6'h23, 6'h00, 0, 1, SD,   4'b0000, 0, 2'b11, 2'b00, 10'b0000000000);
    row(0, 6'h23, 6'h00, 0, 1, SMA,  4'b0000, 1, 2'b10, 2'b00, 10'b0000000000);
    for (int i = 0; i < 3; i++)
      row(0, 6'h23, 6'h00, 0, 0, SMR, 4'b0000, 0, 2'b00, 2'b00, 10'b0011000000);
    row(0, 6'h23, 6'h00, 0, 1, SMR,  4'b0000, 0, 2'b00, 2'b00, 10'b0011000000);
    row(0, 6'h23, 6'h00, 0, 1, SMWB, 4'b0000, 0, 2'b00, 2'b00, 10'b0000010110);
    // sw with one stall in MEM_WRITE
    row(0, 6'h2B, 6'h00, 0, 1, SF,  4'b0000, 0, 2'b01, 2'b00, 10'b1101000000);
    row(0, 6'h2B, 6'h00, 0, 1, SD,  4'b0000, 0, 2'b11, 2'b00, 10'b0000000000);
    row(0, 6'h2B, 6'h00, 0, 1, SMA, 4'b0000, 1, 2'b10, 2'b00, 10'b0000000000);
    row(0, 6'h2B, 6'h00, 0, 0, SMW, 4'b0000, 0, 2'b00, 2'b00, 10'b0010100000);
    row(0, 6'h2B, 6'h00, 0, 1, SMW, 4'b0000, 0, 2'b00, 2'b00, 10'b0010100010);
    // branches
    br_instr(6'h04, 1, 1);
    br_instr(6'h04, 0, 0);
    br_instr(6'h05, 0, 1);
    br_instr(6'h05, 1, 0);
    // addi
    row(0, 6'h08, 6'h00, 0, 1, SF,  4'b0000, 0, 2'b01, 2'b00, 10'b1101000000);
    row(0, 6'h08, 6'h00, 0, 1, SD,  4'b0000, 0, 2'b11, 2'b00, 10'b0000000000);
    row(0, 6'h08, 6'h00, 0, 1, SAE, 4'b0000, 1, 2'b10, 2'b00, 10'b0000000000);
    row(0, 6'h08, 6'h00, 0, 1, SAW, 4'b0000, 0, 2'b00, 2'b00, 10'b0000010010);
    // jump
    row(0, 6'h02, 6'h00, 0, 1, SF,  4'b0000, 0, 2'b01, 2'b00, 10'b1101000000);
    row(0, 6'h02, 6'h00, 0, 1, SD,  4'b0000, 0, 2'b11, 2'b00, 10'b0000000000);
    row(0, 6'h02, 6'h00, 0, 1, SJ,  4'b0000, 0, 2'b00, 2'b10, 10'b1000000010);
    // illegal opcode and illegal R funct
    illegal_instr(6'h3F, 6'h00);
    illegal_instr(6'h00, 6'h01);
    // reset mid-lw: abort in MEM_READ, forced zeros, FETCH after release
    row(0, 6'h23, 6'h00, 0, 1, SF,  4'b0000, 0, 2'b01, 2'b00, 10'b1101000000);
    row(0, 6'h23, 6'h00, 0, 1, SD,  4'b0000, 0, 2'b11, 2'b00, 10'b0000000000);
    row(0, 6'h23, 6'h00, 0, 1, SMA, 4'b0000, 1, 2'b10, 2'b00, 10'b0000000000);
    row(0, 6'h23, 6'h00, 0, 0, SMR, 4'b0000, 0, 2'b00, 2'b00, 10'b0011000000);
    row(1, 6'h23, 6'h00, 0, 1, SMR, 4'b0000, 0, 2'b00, 2'b00, 10'b0000000000);
    row(1, 6'h23, 6'h00, 0, 1, SF,  4'b0000, 0, 2'b00, 2'b00, 10'b0000000000);
    row(0, 6'h23, 6'h00, 0, 0, SF,  4'b0000, 0, 2'b01, 2'b00, 10'b0001000000);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; opcode = tbl[i].op; funct = tbl[i].fn;
      zero_flag = tbl[i].z; mem_ready = tbl[i].mr;
      #3;
      check_out($sformatf("row%0d", i), sample(), tbl[i].exp, tbl[i].rst);
      check_int($sformatf("rw_excl_row%0d", i), int'(mem_read & mem_write), 0);
      step();
    end

    // lw with 3-cycle MEM_READ stall: retire on cycle 8, read request held while stalled
    rst = 0; opcode = 6'h23; funct = 0; zero_flag = 0;
    cyc = 0; viol = 0; seen = 0;
    for (k = 0; k < 20 && !seen; k++) begin
      mem_ready = (k >= 3 && k < 6) ? 1'b0 : 1'b1;
      #3;
      if (k >= 3 && k <= 6 && !(mem_read && iord)) viol++;
      cyc = k + 1;
      seen = instr_done;
      step();
    end
    check_int("lw_seen_done", int'(seen), 1);
    check_int("lw_total_cycles", cyc, 8);
    check_int("lw_read_held", viol, 0);

    // sw: single retire coincident with mem_ready, never a register write
    opcode = 6'h2B; done_cnt = 0; rw_cnt = 0; viol = 0;
    for (k = 0; k < 5; k++) begin
      mem_ready = (k == 3) ? 1'b0 : 1'b1;
      #3;
      if (instr_done) done_cnt++;
      if (reg_write) rw_cnt++;
      if (instr_done && !mem_ready) viol++;
      step();
    end
    check_int("sw_done_count", done_cnt, 1);
    check_int("sw_reg_write", rw_cnt, 0);
    check_int("sw_done_with_ready", viol, 0);
    mem_ready = 0;
    #3;
    check_int("sw_back_to_fetch", int'(state), int'(SF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
